mem_bus_interconnect: RTL
=========================

// Module: mem_bus_interconnect
// PURPOSE
//  Single-master to 4-slave router between the PicoRV32 native memory bus and the SoC slaves:
//  progmem, data RAM, UART and SPI. It sits directly upstream of progmem and drives progmem's valid/addr.
//  Registers each response and write-protects program memory.
//  Returns an error word for unmapped or timed-out accesses.
// PARAMETERS
//  ERR_DATA        32'hDEAD_BEEF  rdata returned on decode miss or timeout
//  TIMEOUT_CYCLES  255            max WAIT cycles before abort (only with MEM_BUS_TIMEOUT_EN)
// PORTS
//  clk        in   1   clock
//  rstn       in   1   asynchronous, active-low reset
//  mem_valid  in   1   master request
//  mem_instr  in   1   instruction fetch (informational, not decoded)
//  mem_ready  out  1   one-cycle response strobe
//  mem_addr   in   32  byte address
//  mem_wdata  in   32  write data
//  mem_wstrb  in   4   byte enables; 0 = read
//  mem_rdata  out  32  registered read data, valid while mem_ready=1
//  s_valid    out  4   per-slave request [0]=PROG [1]=RAM [2]=UART [3]=SPI
//  s_ready    in   4   per-slave ready
//  s_addr     out  32  shared slave address (registered copy of mem_addr)
//  s_wdata    out  32  shared write data
//  s_wstrb    out  4   shared byte enables
//  s_rdata    in   128 slave read data, slave i at [32*i+31:32*i]
//  bus_err    out  1   one-cycle pulse on miss or timeout
//  err_addr   out  32  address of the last erroring access
// BEHAVIOUR
//  - Decode: PROG 0x0010_0000-0x001F_FFFF; RAM 0x0020_0000-0x002F_FFFF; UART 0x2000_0000-0x2000_FFFF;
//    SPI 0x2001_0000-0x2001_FFFF. Anything else is a miss.
//  - Reset: state=IDLE. All outputs are 0: mem_ready, mem_rdata, s_valid, s_addr, s_wdata, s_wstrb, bus_err, err_addr.
//    Reset mid-transaction aborts immediately. There is no response to the master.
//  - FSM IDLE->WAIT/RESP/ERR->IDLE:
//    IDLE: on mem_valid, register addr, wdata and wstrb, then branch:
//      hit, not a PROG write: set s_valid[i] and go to WAIT.
//      PROG with wstrb!=0: write is dropped; go to RESP with rdata=0 (no bus_err).
//      miss: go to ERR.
//    WAIT: s_valid[i] is held until s_ready[i]=1 is sampled.
//      On that edge: clear s_valid, capture s_rdata[i] into mem_rdata, go to RESP.
//    RESP: mem_ready=1 for exactly one cycle, then go to IDLE.
//    ERR: mem_ready=1, mem_rdata=ERR_DATA, bus_err=1, err_addr<=s_addr for one cycle, then go to IDLE.
//  - Latency: mem_ready rises 1 cycle after the slave's ready is first high.
//    Progmem read: mem_valid in cycle 0 -> s_valid in cycle 1 -> s_ready in cycle 2 -> mem_ready in cycle 3.
//  - At least one IDLE cycle separates transactions. Consequently a lingering s_ready, which progmem keeps for
//    one cycle after valid drops, never completes a new request.
//  - s_ready is ignored outside WAIT and for non-selected slaves. At most one s_valid bit is high.
//  - mem_rdata holds its value after mem_ready until the next response.
// CONFIGURATION
//  MEM_BUS_TIMEOUT_EN defined:
//    an 8-bit counter is cleared on entry to WAIT and increments each WAIT cycle.
//    When the count reaches TIMEOUT_CYCLES without s_ready: clear s_valid and go to ERR (ERR_DATA, bus_err).
//  MEM_BUS_TIMEOUT_EN undefined:
//    no counter; WAIT lasts until s_ready.
// STRUCTURE
//  - Package mem_bus_pkg: slave index constants, region base/mask localparams, state enum {IDLE,WAIT,RESP,ERR},
//    default ERR_DATA.
//  - Sub-module mem_bus_decode: combinational addr -> {hit, onehot sel[3:0]}.
//  - FSM, registers and response mux live in this module.
// TESTING
//  1. Read 0x0010_0008, progmem model with 1-cycle registered ready, word=0x0000_0793
//     -> mem_ready in cycle 3, mem_rdata=0x0000_0793, s_valid[0] high exactly 2 cycles.
//  2. Write 0x2000_000C wdata=0x41 wstrb=4'hF, UART ready after 4 cycles
//     -> s_valid[2] held 4 cycles, s_wdata=0x41, a single mem_ready.
//  3. Write 0x0010_0000 wstrb=4'hF -> no s_valid pulse, mem_ready with rdata=0, bus_err=0.
//  4. Read 0x3000_0000 -> mem_ready with mem_rdata=0xDEAD_BEEF, bus_err pulse, err_addr=0x3000_0000.
//  5. MEM_BUS_TIMEOUT_EN, read 0x2001_0000 with SPI ready stuck at 0
//     -> abort after 255 WAIT cycles, ERR_DATA returned, s_valid[3]=0 after the abort.
//  6. Assert rstn low in WAIT, then issue a fresh progmem read
//     -> all outputs 0 during reset; the next read completes normally with no stale ready.

Source files
------------

// File: rtl/mem_bus_pkg.sv
// Shared constants for the PicoRV32 memory-bus interconnect: slave indices, address
// regions, FSM state encoding and the default error word.
package mem_bus_pkg;

    localparam int unsigned SLV_PROG   = 0;
    localparam int unsigned SLV_RAM    = 1;
    localparam int unsigned SLV_UART   = 2;
    localparam int unsigned SLV_SPI    = 3;
    localparam int unsigned NUM_SLAVES = 4;

    localparam logic [31:0] PROG_BASE = 32'h0010_0000;
    localparam logic [31:0] PROG_MASK = 32'hFFF0_0000;
    localparam logic [31:0] RAM_BASE  = 32'h0020_0000;
    localparam logic [31:0] RAM_MASK  = 32'hFFF0_0000;
    localparam logic [31:0] UART_BASE = 32'h2000_0000;
    localparam logic [31:0] UART_MASK = 32'hFFFF_0000;
    localparam logic [31:0] SPI_BASE  = 32'h2001_0000;
    localparam logic [31:0] SPI_MASK  = 32'hFFFF_0000;

    localparam logic [31:0] ERR_DATA_DEFAULT = 32'hDEAD_BEEF;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP,
        ERR
    } state_e;

    // Every region is at least 64 KiB aligned, so only the upper half-word matters.
    function automatic logic region_match(input logic [15:0] addr_hi,
                                          input logic [31:0] base,
                                          input logic [31:0] mask);
        return (addr_hi & mask[31:16]) == base[31:16];
    endfunction

endpackage

// File: rtl/mem_bus_decode.sv
// Combinational address decoder: upper address half-word -> hit flag and one-hot slave select.
module mem_bus_decode
    import mem_bus_pkg::*;
(
    input  logic [15:0] addr_hi_i,
    output logic        hit_o,
    output logic [3:0]  sel_o
);

    always_comb begin
        sel_o           = '0;
        sel_o[SLV_PROG] = region_match(addr_hi_i, PROG_BASE, PROG_MASK);
        sel_o[SLV_RAM]  = region_match(addr_hi_i, RAM_BASE,  RAM_MASK);
        sel_o[SLV_UART] = region_match(addr_hi_i, UART_BASE, UART_MASK);
        sel_o[SLV_SPI]  = region_match(addr_hi_i, SPI_BASE,  SPI_MASK);
        hit_o           = |sel_o;
    end

endmodule

// File: rtl/mem_bus_interconnect.sv
// Single-master to 4-slave router for the PicoRV32 native bus with registered responses,
// progmem write protection and error word on miss. Optional WAIT timeout: MEM_BUS_TIMEOUT_EN.
module mem_bus_interconnect
    import mem_bus_pkg::*;
#(
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEFAULT,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         mem_valid,
    input  logic         mem_instr,
    output logic         mem_ready,
    input  logic [31:0]  mem_addr,
    input  logic [31:0]  mem_wdata,
    input  logic [3:0]   mem_wstrb,
    output logic [31:0]  mem_rdata,
    output logic [3:0]   s_valid,
    input  logic [3:0]   s_ready,
    output logic [31:0]  s_addr,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
    input  logic [127:0] s_rdata,
    output logic         bus_err,
    output logic [31:0]  err_addr
);

    state_e      state_q, state_d;
    logic [3:0]  s_valid_q, s_valid_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] rdata_q, rdata_d;
    logic [31:0] err_addr_q, err_addr_d;

    logic        dec_hit;
    logic [3:0]  dec_sel;
    logic        slv_ready;
    logic [31:0] slv_rdata;
    logic        unused_instr;

    assign unused_instr = mem_instr;

    mem_bus_decode u_decode (
        .addr_hi_i (mem_addr[31:16]),
        .hit_o     (dec_hit),
        .sel_o     (dec_sel)
    );

    // s_valid_q is one-hot during WAIT, so it doubles as the response-mux select.
    assign slv_ready = |(s_ready & s_valid_q);

    always_comb begin
        slv_rdata = '0;
        for (int unsigned i = 0; i < NUM_SLAVES; i++) begin
            if (s_valid_q[i]) slv_rdata = slv_rdata | s_rdata[32*i +: 32];
        end
    end

`ifdef MEM_BUS_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
    logic [7:0] cnt_q, cnt_d;
`else
    localparam int unsigned UNUSED_TIMEOUT = TIMEOUT_CYCLES;
`endif

    always_comb begin
        state_d    = state_q;
        s_valid_d  = s_valid_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        rdata_d    = rdata_q;
        err_addr_d = err_addr_q;
`ifdef MEM_BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (mem_valid) begin
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    if (!dec_hit) begin
                        state_d    = ERR;
                        rdata_d    = ERR_DATA;
                        err_addr_d = mem_addr;
                    end else if (dec_sel[SLV_PROG] && (mem_wstrb != '0)) begin
                        state_d = RESP;
                        rdata_d = '0;
                    end else begin
                        state_d   = WAIT;
                        s_valid_d = dec_sel;
`ifdef MEM_BUS_TIMEOUT_EN
                        cnt_d     = '0;
`endif
                    end
                end
            end
            WAIT: begin
                if (slv_ready) begin
                    state_d   = RESP;
                    s_valid_d = '0;
                    rdata_d   = slv_rdata;
                end
`ifdef MEM_BUS_TIMEOUT_EN
                else if (cnt_q == TO_LAST) begin
                    state_d    = ERR;
                    s_valid_d  = '0;
                    rdata_d    = ERR_DATA;
                    err_addr_d = addr_q;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
`endif
            end
            RESP:    state_d = IDLE;
            ERR:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            s_valid_q  <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            rdata_q    <= '0;
            err_addr_q <= '0;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            s_valid_q  <= s_valid_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            rdata_q    <= rdata_d;
            err_addr_q <= err_addr_d;
`ifdef MEM_BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
`endif
        end
    end

    assign mem_ready = (state_q == RESP) || (state_q == ERR);
    assign bus_err   = (state_q == ERR);
    assign mem_rdata = rdata_q;
    assign s_valid   = s_valid_q;
    assign s_addr    = addr_q;
    assign s_wdata   = wdata_q;
    assign s_wstrb   = wstrb_q;
    assign err_addr  = err_addr_q;

endmodule
